multiplexed_hex_display: RTL and testbench



---
 rtl/hex_display_pkg.sv | 21 ++
 rtl/hex_to_seg_decoder.sv | 11 +
 rtl/multiplexed_hex_display.sv | 129 ++++++++++++
 tb/tb_multiplexed_hex_display.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display: segment codes and sizing helper.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_to_seg_decoder.sv
// Nibble to active-low seven-segment pattern.
module hex_to_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_CODES[nibble];

endmodule

// File: rtl/multiplexed_hex_display.sv
// Scans an N-digit common-anode display from a frame-aligned shadow copy of the value,
// with guard time, PWM dimming, per-digit enables/dots and leading-zero blanking.
module multiplexed_hex_display
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic [NUM_DIGITS-1:0]   DOTS,
    input  logic [NUM_DIGITS-1:0]   DIGIT_ENABLE,
    input  logic                    LZ_BLANK,
    input  logic [3:0]              BRIGHTNESS,
    input  logic                    LOAD,
    output logic [7:0]              HEX_TO_CELL,
    output logic [NUM_DIGITS-1:0]   SEGMENT_SELECT,
    output logic                    FRAME_DONE
);

    localparam int SW = clog2(REFRESH_DIV);
    localparam int DW = clog2(NUM_DIGITS);

    logic [SW-1:0]             slot_cnt;
    logic [DW-1:0]             digit_idx;
    logic [3:0]                pwm_cnt;

    logic [4*NUM_DIGITS-1:0]   pend_value, shad_value;
    logic [NUM_DIGITS-1:0]     pend_dots, shad_dots;
    logic [NUM_DIGITS-1:0]     pend_en, shad_en;
    logic                      pend_valid;

    logic                      slot_last, digit_last, boundary;
    logic [3:0]                cur_nibble;
    logic                      cur_dot, cur_en, cur_blank, zero_above, lit;
    logic [6:0]                dec_seg, seg_code;
    logic [7:0]                hex_next;
    logic [NUM_DIGITS-1:0]     sel_next;

    assign slot_last  = (slot_cnt == SW'(REFRESH_DIV - 1));
    assign digit_last = (digit_idx == DW'(NUM_DIGITS - 1));
    assign boundary   = slot_last && digit_last;

    // Walk from the top digit down so zero_above covers nibbles i..N-1 when digit i is reached
    always_comb begin
        cur_nibble = 4'h0;
        cur_dot    = 1'b0;
        cur_en     = 1'b0;
        cur_blank  = 1'b0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (shad_value[4*i +: 4] == 4'h0);
            if (digit_idx == DW'(i)) begin
                cur_nibble = shad_value[4*i +: 4];
                cur_dot    = shad_dots[i];
                cur_en     = shad_en[i];
                cur_blank  = (i != 0) && zero_above;
            end
        end
    end

    hex_to_seg_decoder u_decoder (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    assign lit      = (slot_cnt >= SW'(GUARD_CYCLES)) && (pwm_cnt <= BRIGHTNESS) && cur_en;
    assign seg_code = (LZ_BLANK && cur_blank) ? SEG_BLANK : dec_seg;
    assign hex_next = lit ? {~cur_dot, seg_code} : 8'hFF;

    always_comb begin
        sel_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (digit_idx == DW'(i))) sel_next[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            slot_cnt       <= '0;
            digit_idx      <= '0;
            pwm_cnt        <= '0;
            pend_value     <= '0;
            pend_dots      <= '0;
            pend_en        <= '0;
            pend_valid     <= 1'b0;
            shad_value     <= '0;
            shad_dots      <= '0;
            shad_en        <= '0;
            HEX_TO_CELL    <= 8'hFF;
            SEGMENT_SELECT <= '1;
            FRAME_DONE     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_last) begin
                slot_cnt  <= '0;
                digit_idx <= digit_last ? '0 : digit_idx + DW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end

            FRAME_DONE     <= boundary;
            HEX_TO_CELL    <= hex_next;
            SEGMENT_SELECT <= sel_next;

            // Shadow only moves on the frame boundary; a LOAD on that exact cycle bypasses pending
            if (boundary) begin
                pend_valid <= 1'b0;
                if (LOAD) begin
                    shad_value <= VALUE;
                    shad_dots  <= DOTS;
                    shad_en    <= DIGIT_ENABLE;
                end else if (pend_valid) begin
                    shad_value <= pend_value;
                    shad_dots  <= pend_dots;
                    shad_en    <= pend_en;
                end
            end else if (LOAD) begin
                pend_value <= VALUE;
                pend_dots  <= DOTS;
                pend_en    <= DIGIT_ENABLE;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiplexed_hex_display.sv
// Self-checking bench: cycle-indexed reference model of the scan, load and blanking rules.
module tb_multiplexed_hex_display;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 2;
    localparam int FRAME = ND * RD;

    logic        clk, rst;
    logic [15:0] value;
    logic [3:0]  dots, digit_enable, brightness;
    logic        lz_blank, load;
    logic [7:0]  hex_to_cell;
    logic [3:0]  segment_select;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_c;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dots, p_dots, m_en, p_en;
    logic        m_pv;
    logic [6:0]  seg_tab [16];
    logic [7:0]  exp_hex;
    logic [3:0]  exp_sel;
    logic        exp_fd;

    multiplexed_hex_display #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .VALUE          (value),
        .DOTS           (dots),
        .DIGIT_ENABLE   (digit_enable),
        .LZ_BLANK       (lz_blank),
        .BRIGHTNESS     (brightness),
        .LOAD           (load),
        .HEX_TO_CELL    (hex_to_cell),
        .SEGMENT_SELECT (segment_select),
        .FRAME_DONE     (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_c = 0;
        m_val = '0; m_dots = '0; m_en = '0;
        p_val = '0; p_dots = '0; p_en = '0;
        m_pv = 1'b0;
    endtask

    // Predicts the outputs produced by the current cycle, advances the model and the DUT by one clock.
    task automatic tick();
        int slot, d, pwm;
        logic [3:0] nib;
        logic blank;
        slot = m_c % RD;
        d    = (m_c / RD) % ND;
        pwm  = m_c % 16;
        if (slot >= GC && pwm <= int'(brightness) && m_en[d]) begin
            nib     = 4'(m_val >> (4 * d));
            blank   = lz_blank && (d > 0) && ((m_val >> (4 * d)) == 16'h0);
            exp_sel = ~(4'b0001 << d);
            exp_hex = {~m_dots[d], blank ? 7'h7F : seg_tab[nib]};
        end else begin
            exp_sel = 4'hF;
            exp_hex = 8'hFF;
        end
        exp_fd = (m_c % FRAME == FRAME - 1);
        if (exp_fd) begin
            if (load) begin
                m_val = value; m_dots = dots; m_en = digit_enable;
            end else if (m_pv) begin
                m_val = p_val; m_dots = p_dots; m_en = p_en;
            end
            m_pv = 1'b0;
        end else if (load) begin
            p_val = value; p_dots = dots; p_en = digit_enable; m_pv = 1'b1;
        end
        m_c++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (hex_to_cell !== 8'hFF) begin errors++; $display("FAIL reset_hex got %h want ff", hex_to_cell); end
        checks++;
        if (segment_select !== 4'hF) begin errors++; $display("FAIL reset_sel got %h want f", segment_select); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_scan();
        int fd_count;
        fd_count = 0;
        value = 16'h1234; dots = 4'h0; digit_enable = 4'hF; lz_blank = 1'b0; brightness = 4'd15;
        for (int k = 0; k < 3 * FRAME; k++) begin
            load = (k == 0);
            tick();
            if (frame_done === 1'b1) fd_count++;
            checks++;
            if (segment_select !== exp_sel) begin errors++; $display("FAIL scan_sel c=%0d got %h want %h", m_c, segment_select, exp_sel); end
            checks++;
            if (hex_to_cell !== exp_hex) begin errors++; $display("FAIL scan_hex c=%0d got %h want %h", m_c, hex_to_cell, exp_hex); end
            checks++;
            if (frame_done !== exp_fd) begin errors++; $display("FAIL scan_fd c=%0d got %b want %b", m_c, frame_done, exp_fd); end
        end
        load = 1'b0;
        checks++;
        if (fd_count != 3) begin errors++; $display("FAIL scan_fd_count got %0d want 3", fd_count); end
    endtask

    task automatic test_tear_free();
        while (m_c % FRAME != 0) tick();
        for (int k = 0; k < 2 * FRAME; k++) begin
            load  = (k == 12) || (k == 20);
            value = (k == 12) ? 16'hABCD : 16'hFFFF;
            tick();
            checks++;
            if (segment_select !== exp_sel) begin errors++; $display("FAIL tear_sel c=%0d got %h want %h", m_c, segment_select, exp_sel); end
            checks++;
            if (hex_to_cell !== exp_hex) begin errors++; $display("FAIL tear_hex c=%0d got %h want %h", m_c, hex_to_cell, exp_hex); end
        end
        load = 1'b0;
    endtask

    task automatic test_bypass();
        while (m_c % FRAME != FRAME - 1) tick();
        value = 16'h00F0;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        value = 16'h5555;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            checks++;
            if (segment_select !== exp_sel) begin errors++; $display("FAIL bypass_sel c=%0d got %h want %h", m_c, segment_select, exp_sel); end
            checks++;
            if (hex_to_cell !== exp_hex) begin errors++; $display("FAIL bypass_hex c=%0d got %h want %h", m_c, hex_to_cell, exp_hex); end
        end
    endtask

    task automatic test_lz_dots();
        lz_blank = 1'b1;
        dots     = 4'b0010;
        for (int k = 0; k < 4 * FRAME; k++) begin
            load  = (k == 0) || (k == 2 * FRAME);
            value = (k < 2 * FRAME) ? 16'h0070 : 16'h0000;
            tick();
            checks++;
            if (segment_select !== exp_sel) begin errors++; $display("FAIL lz_sel c=%0d got %h want %h", m_c, segment_select, exp_sel); end
            checks++;
            if (hex_to_cell !== exp_hex) begin errors++; $display("FAIL lz_hex c=%0d got %h want %h", m_c, hex_to_cell, exp_hex); end
        end
        load = 1'b0;
        lz_blank = 1'b0;
        dots = 4'h0;
    endtask

    task automatic test_brightness_enable();
        brightness   = 4'd3;
        digit_enable = 4'b0101;
        value        = 16'h8421;
        for (int k = 0; k < 3 * FRAME; k++) begin
            load = (k == 0);
            tick();
            checks++;
            if (segment_select[1] !== 1'b1 || segment_select[3] !== 1'b1) begin
                errors++; $display("FAIL bright_disabled c=%0d got %h want bits1,3 high", m_c, segment_select);
            end
            checks++;
            if (segment_select !== exp_sel) begin errors++; $display("FAIL bright_sel c=%0d got %h want %h", m_c, segment_select, exp_sel); end
            checks++;
            if (hex_to_cell !== exp_hex) begin errors++; $display("FAIL bright_hex c=%0d got %h want %h", m_c, hex_to_cell, exp_hex); end
        end
        load = 1'b0;
        brightness = 4'd15;
        digit_enable = 4'hF;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            value        = 16'($urandom);
            dots         = 4'($urandom);
            digit_enable = 4'($urandom);
            lz_blank     = 1'($urandom);
            brightness   = 4'($urandom);
            load         = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) value = 16'($urandom_range(0, 255));
            tick();
            checks++;
            if (segment_select !== exp_sel) begin errors++; $display("FAIL rand_sel c=%0d got %h want %h", m_c, segment_select, exp_sel); end
            checks++;
            if (hex_to_cell !== exp_hex) begin errors++; $display("FAIL rand_hex c=%0d got %h want %h", m_c, hex_to_cell, exp_hex); end
            checks++;
            if (frame_done !== exp_fd) begin errors++; $display("FAIL rand_fd c=%0d got %b want %b", m_c, frame_done, exp_fd); end
        end
        load = 1'b0;
        lz_blank = 1'b0;
        brightness = 4'd15;
        digit_enable = 4'hF;
        dots = 4'h0;
    endtask

    task automatic test_async_reset();
        value = 16'h9876;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        while (m_c % FRAME != 0) tick();
        while (m_c % FRAME != 2 * RD + 5) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (hex_to_cell !== 8'hFF) begin errors++; $display("FAIL areset_hex got %h want ff", hex_to_cell); end
        checks++;
        if (segment_select !== 4'hF) begin errors++; $display("FAIL areset_sel got %h want f", segment_select); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        value = 16'h5A3C;
        for (int k = 0; k < 2 * FRAME + 4; k++) begin
            load = (k == 0);
            tick();
            checks++;
            if (segment_select !== exp_sel) begin errors++; $display("FAIL restart_sel c=%0d got %h want %h", m_c, segment_select, exp_sel); end
            checks++;
            if (hex_to_cell !== exp_hex) begin errors++; $display("FAIL restart_hex c=%0d got %h want %h", m_c, hex_to_cell, exp_hex); end
            checks++;
            if (frame_done !== exp_fd) begin errors++; $display("FAIL restart_fd c=%0d got %b want %b", m_c, frame_done, exp_fd); end
        end
        load = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b1;
        value = '0; dots = '0; digit_enable = '0; lz_blank = 1'b0;
        brightness = 4'd15; load = 1'b0;
        model_reset();

        test_reset();
        test_scan();
        test_tear_free();
        test_bypass();
        test_lz_dots();
        test_brightness_enable();
        test_async_reset();
        do_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
